ttt_turn_ctrl: RTL and testbench
================================

Name: ttt_turn_ctrl

Overview:
Game-sequencing controller for the tic-tac-toe board datapath.
- Accepts one-hot keypad presses and debounces them, including release.
- Validates each move against the current board, writes the cell, then checks for a win or draw.
- Toggles the turn and owns game-over and restart.
- Drives the board, turn, result and winning-line mask consumed by the 7-segment and dot-matrix display blocks. It is active only while the game screen is selected.

Parameters:
- DEBOUNCE_CYCLES, 25000: consecutive identical clk samples required to accept a key press or a release (sim uses 4).
- CNT_W, 15: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- game_en  in  1  1 = game screen active; 0 = controller idle.
- key_data  in  12  keypad level, one-hot. Bits 0..8 = cells 0..8; bit 11 = restart; bits 9,10 unused. All-zero = no key.
- board  out  18  cell i occupies board[2i+1:2i]: 00 empty, 01 X (P1), 10 O (P2).
- turn_o  out  1  0 = P1/X to move, 1 = P2/O to move.
- winner  out  2  00 none, 01 P1, 10 P2, 11 draw.
- game_over  out  1  result decided.
- win_mask  out  9  cells of the winning line; 0 if no win.
- move_ok  out  1  one-cycle pulse when a move is accepted.
- move_err  out  1  one-cycle pulse when a move is rejected.

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0; FSM state IDLE; debounce counter 0.
- FSM states: IDLE, WAIT_KEY, DEBOUNCE, APPLY, CHECK, WAIT_RELEASE.
- IDLE:
  - Outputs hold.
  - If game_en=1, clear board/turn_o/winner/game_over/win_mask, then go to WAIT_KEY. Entering the game screen always starts a new game.
- game_en=0 in any state: go to IDLE next cycle; board and result hold.
- WAIT_KEY:
  - key_data exactly one-hot: latch the key, counter=1, go to DEBOUNCE.
  - Zero or multi-bit key_data: stay.
- DEBOUNCE:
  - key_data equal to the latched key: increment the counter.
  - When the counter reaches DEBOUNCE_CYCLES, go to APPLY.
  - Any other value (including multi-bit or 0): counter=0, back to WAIT_KEY, no action.
- APPLY (one cycle), by latched key:
  - Cell key, game_over=0, cell empty: write 01 if turn_o=0, else 10. move_ok=1 this cycle. Board change visible from the next edge.
  - Cell key with cell occupied, or game_over=1: board unchanged, move_err=1.
  - Restart key: clear board, turn_o=0, winner=00, game_over=0, win_mask=0. No pulse.
  - Key 9/10: no action, no pulse.
  - Next state: CHECK after an accepted move; WAIT_RELEASE otherwise.
- CHECK (one cycle): evaluate the 8 lines for the mover.
  - Win: winner=mover code, game_over=1, win_mask=line (lowest-index line if two complete at once); turn_o unchanged.
  - Else all 9 cells non-empty: winner=11, game_over=1.
  - Else toggle turn_o.
  - Win takes priority over draw on the 9th move. Go to WAIT_RELEASE.
  - Latency: turn_o/winner update exactly one edge after the board update.
- WAIT_RELEASE:
  - Requires key_data==0 for DEBOUNCE_CYCLES consecutive cycles, then go to WAIT_KEY.
  - Any nonzero value restarts the count.
  - A held key therefore produces exactly one action.
- Invariants:
  - move_ok and move_err are never high together.
  - Each press produces at most one pulse.
  - board never contains 11.
  - After game_over, only restart, game_en toggle or reset clears the result.

Decomposition:
- Shared package ttt_pkg:
  - Cell codes CELL_EMPTY/CELL_X/CELL_O.
  - Winner codes WIN_NONE/WIN_P1/WIN_P2/WIN_DRAW.
  - Key indices KEY_RESTART=11.
  - FSM state enum.
  - WIN_LINES: 8 x 9-bit masks in order rows 0-2, cols 0-2, diag 0-4-8, diag 2-4-6.
- Sub-module ttt_line_check (combinational):
  - Inputs: board, player code.
  - Outputs: win, win_mask, full.

Test Plan (DEBOUNCE_CYCLES=4):
1. rst_n=0 mid-game with key held: all outputs 0 immediately (async). After release and game_en=1, board=0, turn_o=0.
2. game_en=1; key 12'h010 held 4 cycles, then 0 for 4 cycles: board=18'h00100, one move_ok pulse, turn_o=1 one cycle after the board update.
3. Key 12'h010 pressed again: move_err pulse, board unchanged, turn_o stays 1. Key 12'h010 held 50 cycles: exactly one pulse.
4. Key 12'h001 held 2 cycles, dropped, repeated; then 12'h003 held 10 cycles: no board change, no pulses.
5. Moves X0,O3,X1,O4,X2:
   - After the last move: winner=01, game_over=1, win_mask=9'h007, turn_o=0.
   - Then key 12'h100: move_err, board unchanged.
6. Moves X0,O1,X2,O4,X3,O5,X7,O6,X8:
   - winner=11, game_over=1, win_mask=0.
   - Then key 12'h800: all outputs cleared, turn_o=0, no pulse.

Source files
------------

// File: rtl/ttt_pkg.sv
// Shared codes, key indices, FSM states and winning-line masks for the
// tic-tac-toe game controller.
package ttt_pkg;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_X     = 2'b01;
    localparam logic [1:0] CELL_O     = 2'b10;

    localparam logic [1:0] WIN_NONE   = 2'b00;
    localparam logic [1:0] WIN_P1     = 2'b01;
    localparam logic [1:0] WIN_P2     = 2'b10;
    localparam logic [1:0] WIN_DRAW   = 2'b11;

    localparam int unsigned KEY_RESTART = 11;
    localparam int unsigned N_CELLS     = 9;
    localparam int unsigned N_LINES     = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_KEY,
        S_DEBOUNCE,
        S_APPLY,
        S_CHECK,
        S_WAIT_RELEASE
    } state_t;

    // Rows 0-2, columns 0-2, diagonal 0-4-8, diagonal 2-4-6.
    localparam logic [8:0] WIN_LINES [N_LINES] = '{
        9'h007, 9'h038, 9'h1C0,
        9'h049, 9'h092, 9'h124,
        9'h111, 9'h054
    };

endpackage

// File: rtl/ttt_line_check.sv
// Combinational win/full detector: reports the lowest-index completed line
// for the given player and whether every cell is occupied.
module ttt_line_check
    import ttt_pkg::*;
(
    input  logic [17:0] board,
    input  logic [1:0]  player,
    output logic        win,
    output logic [8:0]  win_mask,
    output logic        full
);

    logic [8:0] owned;
    logic [8:0] filled;

    always_comb begin
        owned  = '0;
        filled = '0;
        for (int unsigned i = 0; i < N_CELLS; i++) begin
            owned[i]  = (board[2*i +: 2] == player);
            filled[i] = (board[2*i +: 2] != CELL_EMPTY);
        end
    end

    always_comb begin
        win      = 1'b0;
        win_mask = '0;
        for (int unsigned l = 0; l < N_LINES; l++) begin
            if (!win && ((owned & WIN_LINES[l]) == WIN_LINES[l])) begin
                win      = 1'b1;
                win_mask = WIN_LINES[l];
            end
        end
    end

    assign full = &filled;

endmodule

// File: rtl/ttt_turn_ctrl.sv
// Tic-tac-toe game sequencer: debounces one-hot keypad presses, applies
// moves to the board, detects win/draw and manages turns and restart.
module ttt_turn_ctrl
    import ttt_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 25000,
    parameter int unsigned CNT_W           = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        game_en,
    input  logic [11:0] key_data,
    output logic [17:0] board,
    output logic        turn_o,
    output logic [1:0]  winner,
    output logic        game_over,
    output logic [8:0]  win_mask,
    output logic        move_ok,
    output logic        move_err
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES);

    state_t             state_q, state_d;
    logic [11:0]        key_q, key_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [17:0]        board_q, board_d;
    logic               turn_q, turn_d;
    logic [1:0]         winner_q, winner_d;
    logic               over_q, over_d;
    logic [8:0]         mask_q, mask_d;

    logic               key_onehot;
    logic               key_is_cell;
    logic [3:0]         cell_idx;
    logic [1:0]         mover;
    logic               lc_win;
    logic [8:0]         lc_mask;
    logic               lc_full;

    assign mover       = turn_q ? CELL_O : CELL_X;
    assign key_onehot  = (key_data != '0) && ((key_data & (key_data - 12'd1)) == '0);
    assign key_is_cell = |key_q[8:0];

    always_comb begin
        cell_idx = '0;
        for (int unsigned i = 0; i < N_CELLS; i++) begin
            if (key_q[i]) cell_idx = 4'(i);
        end
    end

    ttt_line_check u_line_check (
        .board    (board_q),
        .player   (mover),
        .win      (lc_win),
        .win_mask (lc_mask),
        .full     (lc_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            key_q    <= '0;
            cnt_q    <= '0;
            board_q  <= '0;
            turn_q   <= 1'b0;
            winner_q <= WIN_NONE;
            over_q   <= 1'b0;
            mask_q   <= '0;
        end else begin
            state_q  <= state_d;
            key_q    <= key_d;
            cnt_q    <= cnt_d;
            board_q  <= board_d;
            turn_q   <= turn_d;
            winner_q <= winner_d;
            over_q   <= over_d;
            mask_q   <= mask_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        key_d    = key_q;
        cnt_d    = cnt_q;
        board_d  = board_q;
        turn_d   = turn_q;
        winner_d = winner_q;
        over_d   = over_q;
        mask_d   = mask_q;
        move_ok  = 1'b0;
        move_err = 1'b0;

        if (!game_en) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    board_d  = '0;
                    turn_d   = 1'b0;
                    winner_d = WIN_NONE;
                    over_d   = 1'b0;
                    mask_d   = '0;
                    cnt_d    = '0;
                    state_d  = S_WAIT_KEY;
                end
                S_WAIT_KEY: begin
                    if (key_onehot) begin
                        key_d   = key_data;
                        cnt_d   = CNT_W'(1);
                        state_d = S_DEBOUNCE;
                    end
                end
                S_DEBOUNCE: begin
                    if (key_data == key_q) begin
                        if (cnt_q + 1'b1 >= DB_LAST) begin
                            cnt_d   = '0;
                            state_d = S_APPLY;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = S_WAIT_KEY;
                    end
                end
                S_APPLY: begin
                    cnt_d   = '0;
                    state_d = S_WAIT_RELEASE;
                    if (key_is_cell) begin
                        if (!over_q && board_q[{cell_idx, 1'b0} +: 2] == CELL_EMPTY) begin
                            board_d[{cell_idx, 1'b0} +: 2] = mover;
                            move_ok = 1'b1;
                            state_d = S_CHECK;
                        end else begin
                            move_err = 1'b1;
                        end
                    end else if (key_q[KEY_RESTART]) begin
                        board_d  = '0;
                        turn_d   = 1'b0;
                        winner_d = WIN_NONE;
                        over_d   = 1'b0;
                        mask_d   = '0;
                    end
                end
                S_CHECK: begin
                    state_d = S_WAIT_RELEASE;
                    if (lc_win) begin
                        winner_d = turn_q ? WIN_P2 : WIN_P1;
                        over_d   = 1'b1;
                        mask_d   = lc_mask;
                    end else if (lc_full) begin
                        winner_d = WIN_DRAW;
                        over_d   = 1'b1;
                    end else begin
                        turn_d = ~turn_q;
                    end
                end
                S_WAIT_RELEASE: begin
                    // Release must be stable as long as a press before re-arming.
                    if (key_data != '0) begin
                        cnt_d = '0;
                    end else if (cnt_q + 1'b1 >= DB_LAST) begin
                        cnt_d   = '0;
                        state_d = S_WAIT_KEY;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign board     = board_q;
    assign turn_o    = turn_q;
    assign winner    = winner_q;
    assign game_over = over_q;
    assign win_mask  = mask_q;

endmodule

// File: tb/tb_ttt_turn_ctrl.sv
// Self-checking bench for ttt_turn_ctrl: directed game scenarios plus random
// presses checked against a cell-array reference model.
module tb_ttt_turn_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        game_en = 1'b0;
    logic [11:0] key_data = '0;
    logic [17:0] board;
    logic        turn_o;
    logic [1:0]  winner;
    logic        game_over;
    logic [8:0]  win_mask;
    logic        move_ok;
    logic        move_err;

    int errors = 0;
    int checks = 0;
    int ok_tot = 0;
    int err_tot = 0;
    int both_tot = 0;

    // Reference model state
    int         m_cell [9];
    int         m_turn;
    int         m_win;
    int         m_over;
    logic [8:0] m_mask;
    int         e_ok = 0;
    int         e_err = 0;
    int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                         '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    always #5 clk = ~clk;

    ttt_turn_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .game_en   (game_en),
        .key_data  (key_data),
        .board     (board),
        .turn_o    (turn_o),
        .winner    (winner),
        .game_over (game_over),
        .win_mask  (win_mask),
        .move_ok   (move_ok),
        .move_err  (move_err)
    );

    always @(negedge clk) begin
        if (move_ok) ok_tot++;
        if (move_err) err_tot++;
        if (move_ok && move_err) both_tot++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic void m_clear();
        for (int i = 0; i < 9; i++) m_cell[i] = 0;
        m_turn = 0;
        m_win  = 0;
        m_over = 0;
        m_mask = '0;
    endfunction

    function automatic void m_press(input int k);
        int me;
        bit found;
        bit full;
        if (k < 9) begin
            if (m_over != 0 || m_cell[k] != 0) begin
                e_err++;
            end else begin
                me = (m_turn != 0) ? 2 : 1;
                m_cell[k] = me;
                e_ok++;
                found = 0;
                for (int l = 0; l < 8; l++) begin
                    if (!found && m_cell[lines[l][0]] == me && m_cell[lines[l][1]] == me
                        && m_cell[lines[l][2]] == me) begin
                        found  = 1;
                        m_win  = me;
                        m_over = 1;
                        m_mask = '0;
                        for (int j = 0; j < 3; j++) m_mask[lines[l][j]] = 1'b1;
                    end
                end
                if (!found) begin
                    full = 1;
                    for (int i = 0; i < 9; i++) if (m_cell[i] == 0) full = 0;
                    if (full) begin
                        m_win  = 3;
                        m_over = 1;
                    end else begin
                        m_turn = 1 - m_turn;
                    end
                end
            end
        end else if (k == 11) begin
            m_clear();
        end
    endfunction

    function automatic logic [17:0] m_board();
        logic [17:0] b;
        b = '0;
        for (int i = 0; i < 9; i++) b[2*i +: 2] = 2'(m_cell[i]);
        return b;
    endfunction

    task automatic press(input logic [11:0] k, input int hold, input int rel);
        @(negedge clk);
        key_data = k;
        repeat (hold) @(negedge clk);
        key_data = '0;
        repeat (rel) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({board, turn_o, winner, game_over, win_mask, move_ok, move_err} !== '0) begin
            errors++;
            $display("FAIL reset_state: outputs=%h required 0",
                     {board, turn_o, winner, game_over, win_mask, move_ok, move_err});
        end
        game_en = 1'b1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        press(12'h001, 4, 8);
        m_press(0);
        checks++;
        if (board !== 18'h00001) begin
            errors++;
            $display("FAIL reset_pre_move: board=%h required 00001", board);
        end
        @(negedge clk);
        key_data = 12'h010;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({board, turn_o, winner, game_over, win_mask, move_ok, move_err} !== '0) begin
            errors++;
            $display("FAIL reset_async: outputs=%h required 0",
                     {board, turn_o, winner, game_over, win_mask, move_ok, move_err});
        end
        @(negedge clk);
        key_data = '0;
        rst_n = 1'b1;
        m_clear();
        repeat (3) @(negedge clk);
        checks++;
        if (board !== '0 || turn_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_restart: board=%h turn=%b required 0/0", board, turn_o);
        end
    endtask

    task automatic test_first_move();
        int ok0, err0;
        ok0 = ok_tot;
        err0 = err_tot;
        @(negedge clk);
        key_data = 12'h010;
        repeat (4) @(negedge clk);
        key_data = '0;
        for (int i = 0; i < 10 && board == '0; i++) @(negedge clk);
        m_press(4);
        checks++;
        if (board !== 18'h00100) begin
            errors++;
            $display("FAIL first_move_board: board=%h required 00100", board);
        end
        checks++;
        if (turn_o !== 1'b0) begin
            errors++;
            $display("FAIL first_move_turn_early: turn=%b required 0", turn_o);
        end
        @(negedge clk);
        checks++;
        if (turn_o !== 1'b1) begin
            errors++;
            $display("FAIL first_move_turn: turn=%b required 1", turn_o);
        end
        repeat (8) @(negedge clk);
        checks++;
        if (ok_tot - ok0 != 1 || err_tot - err0 != 0) begin
            errors++;
            $display("FAIL first_move_pulses: ok=%0d err=%0d required 1/0",
                     ok_tot - ok0, err_tot - err0);
        end
    endtask

    task automatic test_occupied();
        int ok0, err0;
        ok0 = ok_tot;
        err0 = err_tot;
        press(12'h010, 4, 8);
        m_press(4);
        checks++;
        if (err_tot - err0 != 1 || ok_tot - ok0 != 0 || board !== 18'h00100 || turn_o !== 1'b1) begin
            errors++;
            $display("FAIL occupied: err=%0d ok=%0d board=%h turn=%b required 1/0/00100/1",
                     err_tot - err0, ok_tot - ok0, board, turn_o);
        end
        err0 = err_tot;
        press(12'h010, 50, 8);
        m_press(4);
        checks++;
        if (err_tot - err0 != 1 || ok_tot - ok0 != 0) begin
            errors++;
            $display("FAIL held_key: err=%0d ok=%0d required 1/0", err_tot - err0, ok_tot - ok0);
        end
    endtask

    task automatic test_glitch();
        int ok0, err0;
        ok0 = ok_tot;
        err0 = err_tot;
        press(12'h001, 2, 2);
        press(12'h001, 2, 2);
        press(12'h003, 10, 8);
        checks++;
        if (board !== 18'h00100 || ok_tot != ok0 || err_tot != err0 || turn_o !== 1'b1) begin
            errors++;
            $display("FAIL glitch: board=%h ok=%0d err=%0d turn=%b required 00100/0/0/1",
                     board, ok_tot - ok0, err_tot - err0, turn_o);
        end
    endtask

    task automatic test_win();
        int seq [5] = '{0, 3, 1, 4, 2};
        int ok0, err0;
        logic [17:0] b0;
        press(12'h800, 4, 8);
        m_clear();
        ok0 = ok_tot;
        foreach (seq[i]) begin
            press(12'(1) << seq[i], 4, 8);
            m_press(seq[i]);
        end
        checks++;
        if (winner !== 2'b01 || game_over !== 1'b1 || win_mask !== 9'h007 || turn_o !== 1'b0) begin
            errors++;
            $display("FAIL win_result: winner=%b over=%b mask=%h turn=%b required 01/1/007/0",
                     winner, game_over, win_mask, turn_o);
        end
        checks++;
        if (ok_tot - ok0 != 5) begin
            errors++;
            $display("FAIL win_pulses: ok=%0d required 5", ok_tot - ok0);
        end
        b0 = board;
        err0 = err_tot;
        press(12'h100, 4, 8);
        m_press(8);
        checks++;
        if (err_tot - err0 != 1 || board !== b0 || board !== m_board()) begin
            errors++;
            $display("FAIL after_win: err=%0d board=%h required 1/%h", err_tot - err0, board, m_board());
        end
    endtask

    task automatic test_draw();
        int seq [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
        int ok0, err0;
        press(12'h800, 4, 8);
        m_clear();
        foreach (seq[i]) begin
            press(12'(1) << seq[i], 4, 8);
            m_press(seq[i]);
        end
        checks++;
        if (winner !== 2'b11 || game_over !== 1'b1 || win_mask !== 9'h000) begin
            errors++;
            $display("FAIL draw_result: winner=%b over=%b mask=%h required 11/1/000",
                     winner, game_over, win_mask);
        end
        ok0 = ok_tot;
        err0 = err_tot;
        press(12'h800, 4, 8);
        m_clear();
        checks++;
        if ({board, turn_o, winner, game_over, win_mask} !== '0 || ok_tot != ok0 || err_tot != err0) begin
            errors++;
            $display("FAIL restart: outputs=%h ok=%0d err=%0d required 0/0/0",
                     {board, turn_o, winner, game_over, win_mask}, ok_tot - ok0, err_tot - err0);
        end
    endtask

    task automatic test_game_en();
        int ok0;
        press(12'h020, 4, 8);
        m_press(5);
        game_en = 1'b0;
        ok0 = ok_tot;
        press(12'h001, 6, 8);
        checks++;
        if (board !== 18'h00400 || ok_tot != ok0) begin
            errors++;
            $display("FAIL disabled_hold: board=%h ok=%0d required 00400/0", board, ok_tot - ok0);
        end
        game_en = 1'b1;
        repeat (3) @(negedge clk);
        m_clear();
        checks++;
        if (board !== '0 || turn_o !== 1'b0) begin
            errors++;
            $display("FAIL reenable_clear: board=%h turn=%b required 0/0", board, turn_o);
        end
    endtask

    task automatic test_random();
        int r, k, ok0, err0, eok0, eerr0, a, b;
        logic [11:0] kv;
        for (int it = 0; it < 80; it++) begin
            ok0 = ok_tot;
            err0 = err_tot;
            eok0 = e_ok;
            eerr0 = e_err;
            r = $urandom_range(0, 99);
            if (r < 70) begin
                k = $urandom_range(0, 8);
                press(12'(1) << k, $urandom_range(4, 9), 8);
                m_press(k);
            end else if (r < 78) begin
                press(12'h800, $urandom_range(4, 9), 8);
                m_press(11);
            end else if (r < 84) begin
                k = $urandom_range(9, 10);
                press(12'(1) << k, $urandom_range(4, 9), 8);
                m_press(k);
            end else if (r < 92) begin
                k = $urandom_range(0, 8);
                press(12'(1) << k, $urandom_range(1, 3), 8);
            end else begin
                a = $urandom_range(0, 11);
                b = (a + $urandom_range(1, 11)) % 12;
                kv = '0;
                kv[a] = 1'b1;
                kv[b] = 1'b1;
                press(kv, 6, 8);
            end
            checks++;
            if (board !== m_board()) begin
                errors++;
                $display("FAIL rand_board[%0d]: board=%h required %h", it, board, m_board());
            end
            checks++;
            if (turn_o !== m_turn[0]) begin
                errors++;
                $display("FAIL rand_turn[%0d]: turn=%b required %0d", it, turn_o, m_turn);
            end
            checks++;
            if (winner !== 2'(m_win) || game_over !== m_over[0]) begin
                errors++;
                $display("FAIL rand_result[%0d]: winner=%b over=%b required %0d/%0d",
                         it, winner, game_over, m_win, m_over);
            end
            checks++;
            if (win_mask !== m_mask) begin
                errors++;
                $display("FAIL rand_mask[%0d]: mask=%h required %h", it, win_mask, m_mask);
            end
            checks++;
            if (ok_tot - ok0 != e_ok - eok0 || err_tot - err0 != e_err - eerr0) begin
                errors++;
                $display("FAIL rand_pulses[%0d]: ok=%0d err=%0d required %0d/%0d",
                         it, ok_tot - ok0, err_tot - err0, e_ok - eok0, e_err - eerr0);
            end
        end
        checks++;
        if (both_tot != 0) begin
            errors++;
            $display("FAIL pulse_overlap: both_high=%0d required 0", both_tot);
        end
    endtask

    initial begin
        m_clear();
        test_reset();
        test_first_move();
        test_occupied();
        test_glitch();
        test_win();
        test_draw();
        test_game_en();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
